mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store unit sitting between the kanade32 core's data port and the word-organised RAM. The RAM stores 32-bit words only, has no byte enables, and reads synchronously. This block converts byte/halfword/word CPU requests with byte addresses into word accesses. It performs alignment checks, load lane extraction with sign/zero extension, and read-modify-write for sub-word stores. Memory is big-endian: byte offset 0 is bits 31:24.

## Interface
Parameters:
- none; byte address width fixed at 32, RAM word address width fixed at 30.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held high with stable fields until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- cpu_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for word and stores.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified (byte in 7:0, half in 15:0).
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ready; 1 = misaligned or reserved size, no memory access made.
- cpu_rdata  out  32  load result, valid with cpu_ready and held until next load completes.
- ram_wren  out  1  RAM write enable.
- ram_address  out  30  RAM word address = cpu_addr[31:2].
- ram_data  out  32  RAM write data.
- ram_q  in  32  RAM read data, valid the cycle after the address was presented.

## Operation
- Requests are accepted only in IDLE, when cpu_req=1. The block latches we, size, sign, addr and wdata at that edge.
- Error check at acceptance:
  - Size 3 is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - On error: go to DONE with err=1. No RAM cycle.
- FSM states are IDLE, READ, MERGE, WRITE, DONE.
  - IDLE → READ: load, or sub-word store.
  - IDLE → WRITE: word store.
  - IDLE → DONE: error.
  - READ: ram_address is the latched word address, ram_wren=0. Next state MERGE.
  - MERGE, load: extract lane from ram_q.
    - Byte lane k = addr[1:0] takes bits 31-8k:24-8k.
    - Half lane: addr[1]=0 takes 31:16, addr[1]=1 takes 15:0.
    - Extend per sign, then register into cpu_rdata.
  - MERGE, sub-word store: ram_wren=1 for exactly this cycle. ram_data = ram_q with the target lane replaced by wdata[7:0] or wdata[15:0].
  - MERGE always goes to DONE.
  - WRITE: ram_wren=1 and ram_data = latched wdata. Next state DONE.
  - DONE: cpu_ready=1 and cpu_err as latched. Next state IDLE.
- ram_wren, ram_address and ram_data are decoded from registered state and latched fields only; there is no combinational path from cpu_* inputs.
- In IDLE and DONE: ram_wren=0 and ram_address holds the last latched value.

## Timing
- Cycle 0 is the IDLE cycle in which cpu_req is sampled.
- Completion latency (cpu_ready high):
  - Load: cycle 3.
  - Word store: cycle 2; the RAM write occurs at the end of cycle 1.
  - Sub-word store: cycle 3; the write occurs at the end of cycle 2.
  - Error: cycle 1.
- Back-to-back requests: the next acceptance can occur at the earliest in the cycle after DONE.
- A store followed by a load to the same word returns the new data; the RAM read array reflects the write on the next edge.
- cpu_req held high during DONE does not start a new transaction until IDLE.
- Reset values: state IDLE, cpu_ready=0, cpu_err=0, cpu_rdata=0, ram_wren=0, ram_address=0, ram_data=0, all latched fields 0.
- Reset asserted mid-transaction: immediate return to IDLE and ram_wren drops asynchronously. A pending MERGE write is discarded, and no cpu_ready is issued for the aborted request.

## Structure
- Shared package mem_pkg contains:
  - size encodings SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - the FSM state enum;
  - the RAM word address width constant 30.
- Sub-module mem_lane_align, purely combinational: load lane extract/extend and store lane merge, keyed on size and addr[1:0].
- FSM and registers stay in mem_access_ctrl.

## Test plan
RAM model preloaded with word 0x10 = 0x11223344 and word 0x11 = 0x80FF7F01.
- Signed byte load at 0x44 → cpu_rdata=0xFFFFFF80 in cycle 3. Unsigned byte load at 0x44 → 0x00000080. Signed byte load at 0x41 → 0x00000022.
- Signed half load at 0x44 → 0xFFFF80FF. Signed half load at 0x46 → 0x00007F01.
- Byte store of 0x000000AA to 0x42 → one ram_wren pulse in cycle 2 with ram_address=0x10 and ram_data=0x1122AA44. A following word load at 0x40 returns 0x1122AA44.
- Word store of 0xDEADBEEF to 0x40, then immediate word load at 0x40 → ram_wren in cycle 1 only, ready at cycle 2, then rdata=0xDEADBEEF.
- Word store at 0x41, half load at 0x45, and size=3 → each gives cpu_ready with cpu_err=1 in cycle 1, with ram_wren never asserted.
- Half store to 0x44 with rst_n pulsed low during MERGE → ram_wren low immediately, no cpu_ready, word 0x11 still 0x80FF7F01.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the kanade32 load/store unit: access sizes, FSM states
// and the RAM word-address width.
package mem_pkg;

  localparam int RAM_AW = 30;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Size 3 is reserved; halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = offset[0];
      SIZE_W:  bad = (offset != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: load extract with sign/zero extension and the
// sub-word merge used by read-modify-write stores. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign,
  input  logic [31:0] ram_q,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0:    byte_lane = ram_q[31:24];
      2'd1:    byte_lane = ram_q[23:16];
      2'd2:    byte_lane = ram_q[15:8];
      default: byte_lane = ram_q[7:0];
    endcase
    half_lane = offset[1] ? ram_q[15:0] : ram_q[31:16];
  end

  always_comb begin
    load_data = ram_q;
    case (size)
      SIZE_B:  load_data = {{24{sign & byte_lane[7]}}, byte_lane};
      SIZE_H:  load_data = {{16{sign & half_lane[15]}}, half_lane};
      default: load_data = ram_q;
    endcase
  end

  always_comb begin
    store_data = ram_q;
    case (size)
      SIZE_B: begin
        case (offset)
          2'd0:    store_data[31:24] = wdata[7:0];
          2'd1:    store_data[23:16] = wdata[7:0];
          2'd2:    store_data[15:8]  = wdata[7:0];
          default: store_data[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (offset[1]) store_data[15:0]  = wdata[15:0];
        else           store_data[31:16] = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word CPU requests onto a word-only synchronous RAM.
// Handshake: cpu_req is held with stable fields until the one-cycle cpu_ready pulse.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              ram_wren,
  output logic [RAM_AW-1:0] ram_address,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data, store_data;

  mem_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .sign       (sign_q),
    .ram_q      (ram_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          size_d  = cpu_size;
          sign_d  = cpu_sign;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = access_bad(cpu_size, cpu_addr[1:0]);
          if (err_d)                          state_d = ST_DONE;
          else if (cpu_we && cpu_size == SIZE_W) state_d = ST_WRITE;
          else                                state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        if (!we_q) rdata_d = load_data;
        state_d = ST_DONE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM-side outputs depend only on registered state so reset kills a write at once.
  always_comb begin
    ram_wren  = 1'b0;
    ram_data  = 32'd0;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    case (state_q)
      ST_MERGE: begin
        ram_wren = we_q;
        ram_data = we_q ? store_data : 32'd0;
      end
      ST_WRITE: begin
        ram_wren = 1'b1;
        ram_data = wdata_q;
      end
      ST_DONE: begin
        cpu_ready = 1'b1;
        cpu_err   = err_q;
      end
      default: ;
    endcase
  end

  assign ram_address = addr_q[31:2];
  assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small synchronous word RAM model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [31:0] cpu_rdata;
  logic        ram_wren;
  logic [29:0] ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q = 32'd0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_size    (cpu_size),
    .cpu_sign    (cpu_sign),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_err     (cpu_err),
    .cpu_rdata   (cpu_rdata),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[5:0]] <= ram_data;
    ram_q <= mem[ram_address[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exp_wcyc = 0 means no RAM write is expected during the transaction.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_err, input int exp_wcyc,
                     input logic [31:0] exp_wd, input logic chk_rd, input logic [31:0] exp_rd);
    int cyc, lat, wcnt, wcyc;
    logic [29:0] wa;
    logic [31:0] wd, rd;
    logic err;
    lat = 0; wcnt = 0; wcyc = 0; wa = '0; wd = '0; rd = '0; err = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sign = sign;
    cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0;
    while (lat == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ram_wren) begin
        wcnt++; wcyc = cyc; wa = ram_address; wd = ram_data;
      end
      if (cpu_ready) begin
        lat = cyc; err = cpu_err; rd = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "/wren_count"}, 32'(wcnt), (exp_wcyc != 0) ? 32'd1 : 32'd0);
    if (exp_wcyc != 0) begin
      chk({tag, "/wren_cycle"}, 32'(wcyc), 32'(exp_wcyc));
      chk({tag, "/wr_addr"}, {2'b00, wa}, {2'b00, addr[31:2]});
      chk({tag, "/wr_data"}, wd, exp_wd);
    end
    if (chk_rd) chk({tag, "/rdata"}, rd, exp_rd);
    if (lat != 0) begin
      @(posedge clk); #1;
      chk({tag, "/ready_pulse"}, {31'd0, cpu_ready}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[16] = 32'h11223344;
    mem[17] = 32'h80FF7F01;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_sign = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/ready", {31'd0, cpu_ready}, 32'd0);
    chk("reset/err", {31'd0, cpu_err}, 32'd0);
    chk("reset/rdata", cpu_rdata, 32'd0);
    chk("reset/wren", {31'd0, ram_wren}, 32'd0);
    chk("reset/address", {2'b00, ram_address}, 32'd0);
    chk("reset/data", ram_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads: tag, we, size, sign, addr, wdata, lat, err, wcyc, wdata_exp, chk_rd, rdata_exp
    txn("lb_s_44",  1'b0, 2'd0, 1'b1, 32'h44, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'hFFFFFF80);
    txn("lb_u_44",  1'b0, 2'd0, 1'b0, 32'h44, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h00000080);
    txn("lb_s_41",  1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h00000022);
    txn("lh_s_44",  1'b0, 2'd1, 1'b1, 32'h44, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'hFFFF80FF);
    txn("lh_u_44",  1'b0, 2'd1, 1'b0, 32'h44, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h000080FF);
    txn("lh_s_46",  1'b0, 2'd1, 1'b1, 32'h46, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h00007F01);

    // Sub-word store; the previous load result must stay on cpu_rdata.
    txn("sb_42",    1'b1, 2'd0, 1'b0, 32'h42, 32'hAA, 3, 1'b0, 2, 32'h1122AA44, 1'b1, 32'h00007F01);
    txn("lw_40a",   1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h1122AA44);

    txn("sw_40",    1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 2, 1'b0, 1, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("lw_40b",   1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'hDEADBEEF);
    txn("sh_42",    1'b1, 2'd1, 1'b0, 32'h42, 32'hFFFF1234, 3, 1'b0, 2, 32'hDEAD1234, 1'b0, 32'h0);
    txn("sb_43",    1'b1, 2'd0, 1'b0, 32'h43, 32'hFFFFFF55, 3, 1'b0, 2, 32'hDEAD1255, 1'b0, 32'h0);
    txn("sh_40",    1'b1, 2'd1, 1'b0, 32'h40, 32'h0000CAFE, 3, 1'b0, 2, 32'hCAFE1255, 1'b0, 32'h0);
    txn("lw_40c",   1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'hCAFE1255);

    // Errors: no RAM cycle, ready in cycle 1.
    txn("err_sw41", 1'b1, 2'd2, 1'b0, 32'h41, 32'h12345678, 1, 1'b1, 0, 32'h0, 1'b0, 32'h0);
    txn("err_lh45", 1'b0, 2'd1, 1'b1, 32'h45, 32'h0, 1, 1'b1, 0, 32'h0, 1'b0, 32'h0);
    txn("err_sz3",  1'b0, 2'd3, 1'b0, 32'h44, 32'h0, 1, 1'b1, 0, 32'h0, 1'b0, 32'h0);
    txn("ok_after", 1'b0, 2'd0, 1'b0, 32'h47, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h00000001);

    // Reset asserted while the half store sits in MERGE.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd1; cpu_sign = 1'b0;
    cpu_addr = 32'h44; cpu_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort/merge_wren", {31'd0, ram_wren}, 32'd1);
    cpu_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort/wren_async", {31'd0, ram_wren}, 32'd0);
    chk("abort/ready_async", {31'd0, cpu_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort/ready_in_reset", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort/no_ready", {31'd0, cpu_ready}, 32'd0);
    end
    txn("lw_44_kept", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 3, 1'b0, 0, 32'h0, 1'b1, 32'h80FF7F01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
